// File: rtl/fetch_unit.sv
// fetch_unit: program-counter sequencer. Steps the instruction ROM address,
// resolves BNO/BOF branches against the ALU overflow flag, and handles
// halt, stall and restart. It also keeps a saturating count of RUN cycles.
module fetch_unit #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             branch_on_of,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             overflow,
    output logic [PC_W-1:0]  pc,
    output logic             pc_valid,
    output logic             done,
    output logic             pc_wrap,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             taken;

    // Counter increment that holds at all-ones instead of rolling over.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // BOF is taken on overflow=1 and BNO on overflow=0. The flag is used as
    // presented this cycle; no internal copy is kept.
    assign taken = branch_en & (overflow == branch_on_of);

    // Next-state logic. In RUN the priority is halt, then stall, then branch, then increment.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wrap_d  = wrap_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = sat_inc(cnt_q);
                if (halt) begin
                    state_d = HALTED;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (taken) begin
                    pc_d = branch_target;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                    if (pc_q == {PC_W{1'b1}}) begin
                        wrap_d = 1'b1;
                    end
                end
            end
            HALTED: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_PC;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_PC;
            end
        endcase
    end

    // State registers with a synchronous active-low reset that overrides every input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign pc_valid    = (state_q == RUN);
    assign done        = (state_q == HALTED);
    assign pc_wrap     = wrap_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by random stimulus. The outputs
// are compared against a cycle-level reference model on every clock.
module tb_fetch_unit;

    localparam int PCW    = 6;
    localparam int CW     = 6;
    localparam int PC_MOD = 1 << PCW;
    localparam int CNTMAX = (1 << CW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           halt;
    logic           stall;
    logic           branch_en;
    logic           branch_on_of;
    logic [PCW-1:0] branch_target;
    logic           overflow;
    logic [PCW-1:0] pc;
    logic           pc_valid;
    logic           done;
    logic           pc_wrap;
    logic [CW-1:0]  cycle_count;

    int errors = 0;
    int checks = 0;

    int m_st, m_pc, m_cnt;
    bit m_wrap;

    fetch_unit #(.PC_W(PCW), .START_ADDR(0), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .halt          (halt),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_on_of  (branch_on_of),
        .branch_target (branch_target),
        .overflow      (overflow),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .done          (done),
        .pc_wrap       (pc_wrap),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: one clock edge applied to the model.
    task automatic model_edge();
        if (!rst_n) begin
            m_st = M_IDLE; m_pc = 0; m_wrap = 0; m_cnt = 0;
        end else if (m_st == M_RUN) begin
            if (m_cnt < CNTMAX) m_cnt = m_cnt + 1;
            if (halt) m_st = M_HALT;
            else if (stall) m_pc = m_pc;
            else if (branch_en && (overflow == branch_on_of)) m_pc = int'(branch_target);
            else begin
                if (m_pc + 1 == PC_MOD) m_wrap = 1;
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end else if (start) begin
            m_st = M_RUN; m_pc = 0; m_cnt = 0;
        end
    endtask

    task automatic compare_all();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("pc_valid", 32'(pc_valid), 32'(m_st == M_RUN));
        chk("done", 32'(done), 32'(m_st == M_HALT));
        chk("pc_wrap", 32'(pc_wrap), 32'(m_wrap));
        chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic quiet();
        rst_n = 1; start = 0; halt = 0; stall = 0;
        branch_en = 0; branch_on_of = 0; overflow = 0; branch_target = '0;
    endtask

    task automatic run_to(input int target, input string tag);
        int n = 0;
        quiet();
        while (int'(pc) != target && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(pc), 32'(target));
    endtask

    initial begin
        quiet();
        m_st = M_IDLE; m_pc = 0; m_wrap = 0; m_cnt = 0;

        // Reset for two cycles
        rst_n = 0;
        step(); step();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_valid", 32'(pc_valid), 32'd0);
        chk("rst_cnt", 32'(cycle_count), 32'd0);

        // Start, then free-running increment
        quiet(); start = 1;
        step();
        chk("start_pc", 32'(pc), 32'd0);
        chk("start_valid", 32'(pc_valid), 32'd1);
        quiet();
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("inc_pc", 32'(pc), 32'(i));
            chk("inc_cnt", 32'(cycle_count), 32'(i));
        end

        // BOF taken, then back to 5 with BNO, then BOF not taken
        run_to(5, "reach5");
        branch_en = 1; branch_on_of = 1; overflow = 1; branch_target = 6'h20;
        step();
        chk("bof_taken", 32'(pc), 32'h20);
        branch_on_of = 0; overflow = 0; branch_target = 6'd5;
        step();
        chk("bno_taken", 32'(pc), 32'd5);
        branch_on_of = 1; overflow = 0; branch_target = 6'h20;
        step();
        chk("bof_not_taken", 32'(pc), 32'd6);

        // Halt dominates stall and a taken branch
        run_to(7, "reach7");
        halt = 1; stall = 1; branch_en = 1; branch_on_of = 1; overflow = 1; branch_target = 6'h11;
        step();
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_pc", 32'(pc), 32'd7);
        step(); step();
        chk("halted_pc_hold", 32'(pc), 32'd7);
        quiet(); start = 1;
        step();
        chk("restart_pc", 32'(pc), 32'd0);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_cnt", 32'(cycle_count), 32'd0);

        // Three stall cycles at pc=9
        run_to(9, "reach9");
        stall = 1;
        for (int i = 0; i < 3; i++) step();
        chk("stall_pc", 32'(pc), 32'd9);
        chk("stall_cnt", 32'(cycle_count), 32'd12);
        stall = 0;
        step();
        chk("unstall_pc", 32'(pc), 32'd10);

        // Wrap past the top address; counter saturates on the way
        run_to(PC_MOD - 1, "reach_top");
        chk("wrap_before", 32'(pc_wrap), 32'd0);
        step();
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_set", 32'(pc_wrap), 32'd1);
        chk("cnt_sat", 32'(cycle_count), 32'(CNTMAX));
        step(); step();
        chk("wrap_sticky", 32'(pc_wrap), 32'd1);

        // Reset mid-RUN wins over a taken branch
        run_to(12, "reach12");
        rst_n = 0; branch_en = 1; branch_on_of = 0; overflow = 0; branch_target = 6'h30;
        step();
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_valid", 32'(pc_valid), 32'd0);
        chk("midrst_wrap", 32'(pc_wrap), 32'd0);

        // Random stimulus against the model
        quiet();
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            start         = ($urandom_range(0, 7) == 0);
            halt          = ($urandom_range(0, 31) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_en     = ($urandom_range(0, 3) == 0);
            branch_on_of  = 1'($urandom);
            overflow      = 1'($urandom);
            branch_target = PCW'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
